regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-port integer register file for the dual-issue ID stage. Provides NUM_RD combinational read ports and NUM_WR write ports, with per-port write priority and same-cycle write-to-read forwarding. Includes a post-reset clear sequencer and a pending-write scoreboard feeding the hazard unit. It replaces the single-issue 2R1W register file.

Parameters:
DATA_WIDTH, 32, register width in bits
NUM_REGS, 32, number of architectural registers (power of two, >=2)
NUM_RD, 2, read ports (1..4)
NUM_WR, 2, write ports (1..2)
AW, $clog2(NUM_REGS), address width (derived, do not override)

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  asynchronous, active-low reset (asserted when 0)
rd_addr  in  NUM_RD*AW  read addresses, port k at [k*AW +: AW]
rd_data  out  NUM_RD*DATA_WIDTH  read data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
rd_busy  out  NUM_RD  scoreboard pending bit for each read address
wr_en  in  NUM_WR  write enables
wr_addr  in  NUM_WR*AW  write addresses
wr_data  in  NUM_WR*DATA_WIDTH  write data
sb_set_en  in  1  mark a destination register pending (issue)
sb_set_addr  in  AW  register to mark pending
ready  out  1  high once the clear sequence has finished

Behaviour:
- Reset (rst=0, async): state=INIT, clear counter=0, all scoreboard bits=0, ready=0. Storage array is not asynchronously reset.
- FSM INIT:
  - Each cycle writes 0 to register[counter], then counter+1.
  - When counter==NUM_REGS-1, the next state is RUN. INIT lasts exactly NUM_REGS cycles after rst deasserts.
  - During INIT: all wr_en and sb_set_en are ignored, rd_data=0, rd_busy=0.
- FSM RUN: ready=1. Stays in RUN until rst asserts. Reset mid-RUN returns immediately to INIT.
- Reads are combinational:
  - rd_addr==0 always returns 0 (x0 hardwired).
  - Otherwise returns register[rd_addr], subject to forwarding (Optional Feature).
- Writes:
  - Commit on posedge when wr_en[j]=1 and wr_addr[j]!=0. Writes to x0 are dropped.
  - If two ports write the same address in one cycle, the higher port index wins (the younger instruction).
- Scoreboard, one bit per register, bit 0 constant 0:
  - Set on posedge by sb_set_en (addr!=0).
  - Cleared on posedge by any wr_en[j] to that address.
  - Set and clear of the same register in the same cycle: set wins.
  - rd_busy[k]=busy[rd_addr[k]] registered value; no same-cycle forwarding of clears.
- Latency: write visible on the read port in the same cycle with forwarding, otherwise from the next cycle. Scoreboard changes are visible the cycle after the set/clear.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined:
  - A read whose address matches an active write (wr_en=1, addr!=0) in the same cycle returns that wr_data.
  - Highest matching port index wins.
  - A forwarded register reports rd_busy=0 for that read.
- Undefined: reads return stored array contents only (old value in the write cycle). rd_busy reports the registered bit unchanged.

Decomposition:
- riscv_def.v holds REG_DATA_WIDTH, REG_SIZE and RS_WIDTH; these are the defaults for DATA_WIDTH, NUM_REGS and AW.
- Add to riscv_def.v: RF_ST_INIT=1'b0 and RF_ST_RUN=1'b1.
- One sub-module, regfile_scoreboard:
  - Parameters NUM_REGS and NUM_WR.
  - Holds the busy vector and the set/clear priority.
  - Exposes the full busy vector; regfile_mp indexes it per read port.

Test Plan:
- Release rst, hold wr_en=2'b11 with nonzero data for 32 cycles: ready rises on cycle 32, not before. All 32 registers read 0. No INIT-time write lands.
- RUN, port0 writes x5=0xDEADBEEF: next cycle rd_addr0=5 returns 0xDEADBEEF. The write cycle returns 0xDEADBEEF with REGFILE_BYPASS_EN, 0x00000000 without.
- Both ports write x7 (port0=0x11, port1=0x22) in one cycle: x7 reads 0x22 afterwards, and is forwarded as 0x22 with bypass.
- Write x0=0xFFFFFFFF on both ports, with bypass on: rd_addr=0 returns 0 in the same and the next cycle.
- Scoreboard:
  - sb_set x9: rd_busy=1 the next cycle.
  - Write x9 while sb_set x9 in the same cycle: x9 stays busy.
  - Write x9 alone: rd_busy=0 the next cycle.
- Pull rst low mid-RUN with x3=0x1234 and x4 busy: ready=0 and rd_busy=0 immediately. After release, x3 reads 0 once ready=1.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file: default geometry and
// the clear-sequencer state encoding.
package regfile_mp_pkg;

  localparam int REG_DATA_WIDTH = 32;
  localparam int REG_SIZE       = 32;
  localparam int RS_WIDTH       = $clog2(REG_SIZE);

  typedef enum logic {
    RF_ST_INIT = 1'b0,
    RF_ST_RUN  = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set at issue, cleared
// by writeback; a set beats a clear of the same register in the same cycle.
module regfile_scoreboard import regfile_mp_pkg::*; #(
  parameter  int NUM_REGS = REG_SIZE,
  parameter  int NUM_WR   = 2,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   set_en,
  input  logic [AW-1:0]          set_addr,
  input  logic [NUM_WR-1:0]      wr_en,
  input  logic [NUM_WR*AW-1:0]   wr_addr,
  output logic [NUM_REGS-1:0]    busy
);

  logic [NUM_REGS-1:0] set_vec, clr_vec;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int j = 0; j < NUM_WR; j++)
      if (wr_en[j]) clr_vec[wr_addr[j*AW +: AW]] = 1'b1;
    if (set_en) set_vec[set_addr] = 1'b1;
  end

  // Bit 0 is masked so x0 can never look pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= ((busy & ~clr_vec) | set_vec) & ~NUM_REGS'(1);
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with post-reset clear sequencer and scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writes onto the read ports.
module regfile_mp import regfile_mp_pkg::*; #(
  parameter int DATA_WIDTH = REG_DATA_WIDTH,
  parameter int NUM_REGS   = REG_SIZE,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2,
  parameter int AW         = $clog2(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD*AW-1:0]         rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*AW-1:0]         wr_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
  input  logic                         sb_set_en,
  input  logic [AW-1:0]                sb_set_addr,
  output logic                         ready
);

  rf_state_e               state;
  logic [AW-1:0]           cnt;
  logic                    run;
  logic [NUM_WR-1:0]       wr_act;
  logic [NUM_REGS-1:0]     busy;
  logic [DATA_WIDTH-1:0]   mem [NUM_REGS];

  assign run = (state == RF_ST_RUN);

  always_comb begin
    for (int j = 0; j < NUM_WR; j++)
      wr_act[j] = run && wr_en[j] && (wr_addr[j*AW +: AW] != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RF_ST_INIT;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        RF_ST_INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == AW'(NUM_REGS-1)) begin
            state <= RF_ST_RUN;
            ready <= 1'b1;
          end
        end
        default: ready <= 1'b1;
      endcase
    end
  end

  // Storage has no reset; the INIT sweep zeroes it one entry per cycle.
  // Later ports are applied last so the higher index wins on a collision.
  always_ff @(posedge clk) begin
    if (!run) mem[cnt] <= '0;
    else
      for (int j = 0; j < NUM_WR; j++)
        if (wr_act[j]) mem[wr_addr[j*AW +: AW]] <= wr_data[j*DATA_WIDTH +: DATA_WIDTH];
  end

  regfile_scoreboard #(.NUM_REGS(NUM_REGS), .NUM_WR(NUM_WR)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (run && sb_set_en),
    .set_addr (sb_set_addr),
    .wr_en    (wr_act),
    .wr_addr  (wr_addr),
    .busy     (busy)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0]         ra;
    logic                  hit;
    logic [DATA_WIDTH-1:0] fwd;

    assign ra = rd_addr[k*AW +: AW];

`ifdef REGFILE_BYPASS_EN
    always_comb begin
      hit = 1'b0;
      fwd = '0;
      for (int j = 0; j < NUM_WR; j++)
        if (wr_act[j] && wr_addr[j*AW +: AW] == ra) begin
          hit = 1'b1;
          fwd = wr_data[j*DATA_WIDTH +: DATA_WIDTH];
        end
    end
`else
    assign hit = 1'b0;
    assign fwd = '0;
`endif

    assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = (!run || ra == '0) ? '0 : (hit ? fwd : mem[ra]);
    assign rd_busy[k] = run && busy[ra] && !hit;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: expectations queued at stimulus time and
// popped against DUT outputs; checks both bypass builds.
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk, rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        sb_set_en;
  logic [4:0]  sb_set_addr;
  logic        ready;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  regfile_mp dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic expect_v(input string t, input logic [31:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic chk(input logic [31:0] obs);
    logic [31:0] e;
    string t;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %h, nothing expected", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: got %h expected %h", t, obs, e);
      end
    end
  endtask

  initial begin
    clk = 0; rst = 0;
    wr_en = 2'b11; wr_addr = {5'd7, 5'd3}; wr_data = {32'hAAAA5555, 32'hCAFEF00D};
    sb_set_en = 1; sb_set_addr = 5'd9; rd_addr = {5'd9, 5'd3};
    #2;
    expect_v("rst_ready", 0); chk(32'(ready));
    expect_v("rst_busy", 0);  chk(32'(rd_busy));
    expect_v("rst_rd0", 0);   chk(rd_data[31:0]);
    repeat (2) @(negedge clk);
    rst = 1;

    // INIT: writes and sb_set are held active and must be ignored
    for (int i = 1; i <= 32; i++) begin
      @(posedge clk); #1;
      wr_addr[4:0] = 5'(i);
      expect_v($sformatf("init_ready_c%0d", i), 32'(i == 32)); chk(32'(ready));
      if (i == 16) begin expect_v("init_rd0", 0); chk(rd_data[31:0]); end
    end

    @(negedge clk);
    wr_en = 0; sb_set_en = 0;
    for (int r = 0; r < 32; r += 2) begin
      rd_addr = {5'(r + 1), 5'(r)}; #1;
      expect_v($sformatf("clr_x%0d", r), 0);     chk(rd_data[31:0]);
      expect_v($sformatf("clr_x%0d", r + 1), 0); chk(rd_data[63:32]);
      expect_v("clr_busy", 0);                   chk(32'(rd_busy));
    end

    // x5 single write
    @(negedge clk);
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF}; rd_addr = {5'd0, 5'd5};
    expect_v("x5_same", BYP ? 32'hDEADBEEF : 32'h0);
    #1; chk(rd_data[31:0]);
    @(negedge clk); wr_en = 0;
    expect_v("x5_next", 32'hDEADBEEF);
    #1; chk(rd_data[31:0]);

    // dual write to x7: port1 wins
    @(negedge clk);
    wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h22, 32'h11}; rd_addr = {5'd7, 5'd5};
    expect_v("x7_same", BYP ? 32'h22 : 32'h0);
    #1; chk(rd_data[63:32]);
    @(negedge clk); wr_en = 0;
    expect_v("x7_next", 32'h22);
    #1; chk(rd_data[63:32]);

    // writes to x0 are dropped
    @(negedge clk);
    wr_en = 2'b11; wr_addr = {5'd0, 5'd0}; wr_data = {32'hFFFFFFFF, 32'hFFFFFFFF}; rd_addr = {5'd0, 5'd0};
    expect_v("x0_same", 0);
    #1; chk(rd_data[31:0]);
    @(negedge clk); wr_en = 0;
    expect_v("x0_next", 0);
    #1; chk(rd_data[63:32]);

    // scoreboard set
    @(negedge clk);
    sb_set_en = 1; sb_set_addr = 5'd9; rd_addr = {5'd10, 5'd9};
    expect_v("sb_set_same", 0);
    #1; chk(32'(rd_busy[0]));
    @(negedge clk); sb_set_en = 0;
    expect_v("sb_set_next", 1);
    #1; chk(32'(rd_busy[0]));
    expect_v("sb_other", 0); chk(32'(rd_busy[1]));

    // write and set same register: set wins
    @(negedge clk);
    sb_set_en = 1; wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'h99};
    expect_v("sb_setclr_same", BYP ? 0 : 1);
    #1; chk(32'(rd_busy[0]));
    @(negedge clk); sb_set_en = 0; wr_en = 0;
    expect_v("sb_setclr_next", 1);
    #1; chk(32'(rd_busy[0]));

    // clear via port1 writeback
    @(negedge clk);
    wr_en = 2'b10; wr_addr = {5'd9, 5'd0}; wr_data = {32'h9A, 32'h0};
    expect_v("sb_clr_same", BYP ? 0 : 1);
    #1; chk(32'(rd_busy[0]));
    @(negedge clk); wr_en = 0;
    expect_v("sb_clr_next", 0);
    #1; chk(32'(rd_busy[0]));
    expect_v("x9_data", 32'h9A); chk(rd_data[31:0]);

    // reset mid-RUN
    @(negedge clk);
    wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'h1234};
    sb_set_en = 1; sb_set_addr = 5'd4; rd_addr = {5'd4, 5'd3};
    @(negedge clk); wr_en = 0; sb_set_en = 0;
    expect_v("x3_pre", 32'h1234); expect_v("x4_busy_pre", 1);
    #1; chk(rd_data[31:0]); chk(32'(rd_busy[1]));
    #1; rst = 0; #1;
    expect_v("mid_rst_ready", 0); chk(32'(ready));
    expect_v("mid_rst_busy", 0);  chk(32'(rd_busy));
    repeat (2) @(negedge clk);
    rst = 1;
    begin
      int n = 0;
      while (!ready && n < 40) begin @(posedge clk); #1; n++; end
      expect_v("rerun_cycles", 32);
      chk(32'(n));
    end
    expect_v("x3_cleared", 0); chk(rd_data[31:0]);
    expect_v("x4_idle", 0);    chk(32'(rd_busy[1]));

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations: got %0d pending, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
